adder_bist_controller: RTL

//  Built-in self-test driver/checker for the combinational WIDTH-bit adders (a, b, c_0 -> s, c_4).

---
 rtl/adder_bist_controller_pkg.sv | 33 +++
 rtl/adder_bist_controller_vec_gen.sv | 44 ++++
 rtl/adder_bist_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/adder_bist_controller_pkg.sv
//==============================================================================
// Module   : adder_bist_controller_pkg
// Brief    : Shared state encoding and width helpers for the adder BIST.
// Revision : 1.0
//==============================================================================
`default_nettype none

package adder_bist_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

    // Vector layout is {c_0, b, a}, so one extra bit above the two operands.
    function automatic int vec_width(input int width);
        return 2 * width + 1;
    endfunction

    // One more bit than the vector so the count can hold the full vector total.
    function automatic int cnt_width(input int width);
        return 2 * width + 2;
    endfunction

    function automatic int wait_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage : adder_bist_controller_pkg

`default_nettype wire

// File: rtl/adder_bist_controller_vec_gen.sv
//==============================================================================
// Module   : adder_bist_controller_vec_gen
// Brief    : Exhaustive vector counter whose register directly drives the adder.
// Revision : 1.0
//==============================================================================
`default_nettype none

module adder_bist_controller_vec_gen
    import adder_bist_controller_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic             o_last,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic             o_c0
);

    localparam int VW = vec_width(WIDTH);

    logic [VW-1:0] r_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec <= '0;
        end else if (i_clear) begin
            r_vec <= '0;
        end else if (i_advance) begin
            r_vec <= r_vec + VW'(1);
        end
    end

    assign o_last = &r_vec;
    assign o_a    = r_vec[WIDTH-1:0];
    assign o_b    = r_vec[2*WIDTH-1:WIDTH];
    assign o_c0   = r_vec[2*WIDTH];

endmodule : adder_bist_controller_vec_gen

`default_nettype wire

// File: rtl/adder_bist_controller.sv
//==============================================================================
// Module   : adder_bist_controller
// Brief    : Exhaustive BIST driver/checker for a combinational WIDTH-bit adder.
// Revision : 1.0
//==============================================================================
`default_nettype none

module adder_bist_controller
    import adder_bist_controller_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic                 dut_c0,
    input  logic [WIDTH-1:0]     dut_s,
    input  logic                 dut_c4,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic                 fail_vld,
    output logic [2*WIDTH:0]     fail_vec
);

    localparam int                VW          = vec_width(WIDTH);
    localparam int                CW          = cnt_width(WIDTH);
    localparam int                WCW         = wait_width(SETTLE);
    localparam logic [WCW-1:0]    c_WCNT_INIT = WCW'(SETTLE - 1);

    bist_state_e      r_state;
    bist_state_e      w_state_nxt;
    logic [WCW-1:0]   r_wcnt;
    logic             w_start_sweep;
    logic             w_advance;
    logic             w_finish;
    logic             w_check;
    logic             w_last;
    logic [WIDTH:0]   w_expected;
    logic             w_mismatch;

    adder_bist_controller_vec_gen #(
        .WIDTH     (WIDTH)
    ) u_vec_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_start_sweep),
        .i_advance (w_advance),
        .o_last    (w_last),
        .o_a       (dut_a),
        .o_b       (dut_b),
        .o_c0      (dut_c0)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_sweep = 1'b0;
        w_advance     = 1'b0;
        w_finish      = 1'b0;
        w_check       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_start_sweep = 1'b1;
                    w_state_nxt   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_wcnt == '0) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_check = 1'b1;
                if (w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Adder outputs are only trusted in CHECK; anything seen while settling is ignored.
    assign w_expected = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_c0};
    assign w_mismatch = w_check && ({dut_c4, dut_s} != w_expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
        end else if (w_start_sweep || w_advance) begin
            r_wcnt <= c_WCNT_INIT;
        end else if ((r_state == ST_SETTLE) && (r_wcnt != '0)) begin
            r_wcnt <= r_wcnt - WCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            fail_vld  <= 1'b0;
            fail_vec  <= '0;
        end else if (w_start_sweep) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            err_count <= '0;
            fail_vld  <= 1'b0;
            fail_vec  <= '0;
        end else begin
            if (w_mismatch) begin
                err_count <= err_count + CW'(1);
                if (!fail_vld) begin
                    fail_vld <= 1'b1;
                    fail_vec <= VW'({dut_c0, dut_b, dut_a});
                end
            end
            if (w_finish) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign pass = done && (err_count == '0);

endmodule : adder_bist_controller

`default_nettype wire
